// File: rtl/pc_trace_monitor.sv
// rtl/pc_trace_monitor.sv - PC observer: cycle/change counters, halt and misalignment detect, optional trace FIFO
// Optional trace FIFO is built only when PC_TRACE_MON_FIFO_EN is defined.

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module pc_trace_monitor #(
    parameter int PC_WIDTH    = `PC_WIDTH,
    parameter int CNT_WIDTH   = 32,
    parameter int HALT_CYCLES = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PC_WIDTH-1:0]  ext_pc,
    input  logic                 clr,
    output logic                 halted,
    output logic                 misaligned,
    output logic [PC_WIDTH-1:0]  err_pc,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] chg_cnt,
    input  logic                 trace_rd_en,
    output logic [PC_WIDTH-1:0]  trace_data,
    output logic                 trace_empty,
    output logic                 trace_ovf
);

    localparam int SW = (HALT_CYCLES > 2) ? $clog2(HALT_CYCLES) : 1;
    localparam logic [SW-1:0] HALT_LAST = SW'(HALT_CYCLES - 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_ERROR} state_t;

    state_t        state, state_nxt;
    logic [PC_WIDTH-1:0] pc_q;
    logic [SW-1:0] stable_cnt;

    logic chg, bad;
    logic load_pc, cnt_cycle, cnt_chg, push_req;
    logic stable_clr, stable_inc, set_halt, clr_halt, set_err;

    assign chg = (ext_pc != pc_q);
    assign bad = (ext_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_pc    = 1'b0;
        cnt_cycle  = 1'b0;
        cnt_chg    = 1'b0;
        push_req   = 1'b0;
        stable_clr = 1'b0;
        stable_inc = 1'b0;
        set_halt   = 1'b0;
        clr_halt   = 1'b0;
        set_err    = 1'b0;
        case (state)
            S_IDLE: begin
                load_pc   = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bad) begin
                    set_err   = 1'b1;
                    clr_halt  = 1'b1;
                    state_nxt = S_ERROR;
                end else begin
                    load_pc   = 1'b1;
                    cnt_cycle = 1'b1;
                    if (chg) begin
                        cnt_chg    = 1'b1;
                        push_req   = 1'b1;
                        stable_clr = 1'b1;
                    end else begin
                        stable_inc = 1'b1;
                        // the sample that just changed counts as the first identical one
                        if (stable_cnt == HALT_LAST) begin
                            set_halt  = 1'b1;
                            state_nxt = S_HALT;
                        end
                    end
                end
            end
            S_HALT: begin
                if (bad) begin
                    set_err   = 1'b1;
                    clr_halt  = 1'b1;
                    state_nxt = S_ERROR;
                end else if (chg) begin
                    load_pc    = 1'b1;
                    cnt_chg    = 1'b1;
                    push_req   = 1'b1;
                    stable_clr = 1'b1;
                    clr_halt   = 1'b1;
                    state_nxt  = S_RUN;
                end
            end
            S_ERROR: begin
                state_nxt = S_ERROR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            pc_q       <= '0;
            stable_cnt <= '0;
            halted     <= 1'b0;
            misaligned <= 1'b0;
            err_pc     <= '0;
            cycle_cnt  <= '0;
            chg_cnt    <= '0;
        end else begin
            if (load_pc)
                pc_q <= ext_pc;
            if (stable_clr)
                stable_cnt <= '0;
            else if (stable_inc && (stable_cnt != {SW{1'b1}}))
                stable_cnt <= stable_cnt + 1'b1;
            if (set_halt)
                halted <= 1'b1;
            else if (clr_halt)
                halted <= 1'b0;
            if (set_err) begin
                misaligned <= 1'b1;
                err_pc     <= ext_pc;
            end
            if (cnt_cycle && (cycle_cnt != {CNT_WIDTH{1'b1}}))
                cycle_cnt <= cycle_cnt + 1'b1;
            if (cnt_chg && (chg_cnt != {CNT_WIDTH{1'b1}}))
                chg_cnt <= chg_cnt + 1'b1;
        end
    end

`ifdef PC_TRACE_MON_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [PC_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, do_pop, do_push;

    assign trace_empty = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop      = trace_rd_en && !trace_empty;
    // a pop frees the head slot in the same edge, so a full FIFO can still accept
    assign do_push     = rst_n && !clr && push_req && (!full || do_pop);
    assign trace_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            trace_ovf <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_req && full && !do_pop)
                trace_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= ext_pc;
    end
`else
    logic unused_fifo;

    assign unused_fifo = trace_rd_en ^ push_req;
    assign trace_empty = 1'b1;
    assign trace_data  = '0;
    assign trace_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_trace_monitor.sv
// tb/tb_pc_trace_monitor.sv - directed self-checking bench for pc_trace_monitor

module tb_pc_trace_monitor;

    logic        clk;
    logic        rst_n;
    logic [31:0] ext_pc;
    logic        clr;
    logic        halted;
    logic        misaligned;
    logic [31:0] err_pc;
    logic [31:0] cycle_cnt;
    logic [31:0] chg_cnt;
    logic        trace_rd_en;
    logic [31:0] trace_data;
    logic        trace_empty;
    logic        trace_ovf;

    int total = 0;
    int bad   = 0;

    pc_trace_monitor #(
        .PC_WIDTH(32), .CNT_WIDTH(32), .HALT_CYCLES(16), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ext_pc(ext_pc), .clr(clr),
        .halted(halted), .misaligned(misaligned), .err_pc(err_pc),
        .cycle_cnt(cycle_cnt), .chg_cnt(chg_cnt),
        .trace_rd_en(trace_rd_en), .trace_data(trace_data),
        .trace_empty(trace_empty), .trace_ovf(trace_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_misaligned"}, 32'(misaligned), 32'd0);
        check({tag, "_err_pc"}, err_pc, 32'd0);
        check({tag, "_cycle_cnt"}, cycle_cnt, 32'd0);
        check({tag, "_chg_cnt"}, chg_cnt, 32'd0);
        check({tag, "_trace_empty"}, 32'(trace_empty), 32'd1);
        check({tag, "_trace_ovf"}, 32'(trace_ovf), 32'd0);
    endtask

    initial begin
        clk         = 1'b0;
        rst_n       = 1'b0;
        clr         = 1'b0;
        ext_pc      = 32'h0;
        trace_rd_en = 1'b0;

        repeat (4) tick();
        check_cleared("reset");

        // sequential PCs: every RUN sample is a change
        rst_n = 1'b1;
        tick();
        check("idle_chg", chg_cnt, 32'd0);
        check("idle_cycle", cycle_cnt, 32'd0);
        for (int i = 1; i <= 15; i++) begin
            ext_pc = 32'(4 * i);
            tick();
            check("seq_chg", chg_cnt, 32'(i));
            check("seq_cycle", cycle_cnt, 32'(i));
            check("seq_halted", 32'(halted), 32'd0);
        end

        // self-loop: 16 identical samples of 0x40 declare halt
        ext_pc = 32'h40;
        tick();
        check("loop_chg", chg_cnt, 32'd16);
        repeat (14) tick();
        check("loop_15th_halted", 32'(halted), 32'd0);
        check("loop_15th_cycle", cycle_cnt, 32'd30);
        tick();
        check("loop_16th_halted", 32'(halted), 32'd1);
        check("loop_16th_cycle", cycle_cnt, 32'd31);
        tick();
        check("halt_frozen_cycle", cycle_cnt, 32'd31);
        check("halt_frozen_chg", chg_cnt, 32'd16);

        ext_pc = 32'h44;
        tick();
        check("unhalt_halted", 32'(halted), 32'd0);
        check("unhalt_chg", chg_cnt, 32'd17);
        check("unhalt_cycle", cycle_cnt, 32'd31);

        // 17 pushes so far: 0x44 was dropped
`ifdef PC_TRACE_MON_FIFO_EN
        check("ovf_set", 32'(trace_ovf), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            check("pop_empty_flag", 32'(trace_empty), 32'd0);
            check("pop_data", trace_data, 32'(4 * i));
            trace_rd_en = 1'b1;
            tick();
            trace_rd_en = 1'b0;
        end
        check("drained_empty", 32'(trace_empty), 32'd1);
        trace_rd_en = 1'b1;
        tick();
        trace_rd_en = 1'b0;
        check("pop_while_empty", 32'(trace_empty), 32'd1);
        check("ovf_sticky", 32'(trace_ovf), 32'd1);
`else
        check("nofifo_empty", 32'(trace_empty), 32'd1);
        check("nofifo_data", trace_data, 32'd0);
        check("nofifo_ovf", 32'(trace_ovf), 32'd0);
        repeat (17) tick();
`endif
        // 15 RUN samples of 0x44 counted before halting, then HALT
        check("relooped_halted", 32'(halted), 32'd1);
        check("relooped_cycle", cycle_cnt, 32'd46);

        ext_pc = 32'h48;
        tick();
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_chg", chg_cnt, 32'd18);
        check("resume_cycle", cycle_cnt, 32'd46);

        // misaligned fetch in RUN
        ext_pc = 32'h22;
        tick();
        check("mis_flag", 32'(misaligned), 32'd1);
        check("mis_err_pc", err_pc, 32'h22);
        check("mis_halted", 32'(halted), 32'd0);
        check("mis_chg", chg_cnt, 32'd18);
        ext_pc = 32'h30;
        tick();
        check("err_chg_frozen", chg_cnt, 32'd18);
        ext_pc = 32'h26;
        tick();
        check("err_pc_first", err_pc, 32'h22);
        check("err_mis_sticky", 32'(misaligned), 32'd1);
`ifdef PC_TRACE_MON_FIFO_EN
        check("err_head", trace_data, 32'h48);
        trace_rd_en = 1'b1;
        tick();
        trace_rd_en = 1'b0;
        check("err_no_push", 32'(trace_empty), 32'd1);
`endif

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_cleared("clr");

        // back in IDLE: first sample only loads
        ext_pc = 32'h100;
        tick();
        check("clr_idle_chg", chg_cnt, 32'd0);
        check("clr_idle_cycle", cycle_cnt, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            ext_pc = 32'h100 + 32'(4 * i);
            tick();
        end
        check("fill_chg", chg_cnt, 32'd16);
        check("fill_ovf", 32'(trace_ovf), 32'd0);

        // push and pop together while full
        ext_pc      = 32'h144;
        trace_rd_en = 1'b1;
        tick();
        trace_rd_en = 1'b0;
        check("full_pushpop_ovf", 32'(trace_ovf), 32'd0);
        check("full_pushpop_chg", chg_cnt, 32'd17);
`ifdef PC_TRACE_MON_FIFO_EN
        for (int i = 0; i < 16; i++) begin
            check("full_empty_flag", 32'(trace_empty), 32'd0);
            check("full_data", trace_data, 32'h108 + 32'(4 * i));
            trace_rd_en = 1'b1;
            tick();
            trace_rd_en = 1'b0;
        end
        check("full_drained", 32'(trace_empty), 32'd1);
        check("full_no_ovf", 32'(trace_ovf), 32'd0);
`endif

        // reset mid-stream
        ext_pc = 32'h148;
        tick();
        ext_pc = 32'h14C;
        rst_n  = 1'b0;
        tick();
        check_cleared("midrst");
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
